// File: rtl/lcd_bus_reader_if.sv
// Read-request handshake between a client and the HD44780 read engine.
interface lcd_bus_reader_if;
    logic       rd_req;
    logic       rd_rs;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;

    modport master (
        output rd_req, rd_rs,
        input  rd_ready, rd_valid, rd_data
    );

    modport slave (
        input  rd_req, rd_rs,
        output rd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/lcd_bus_reader.sv
// HD44780 read-cycle engine (RW=1): fetches BF/AC or DDRAM/CGRAM data from DATA_BUS.
// Optional busy-flag polling is enabled by defining LCD_RD_BUSY_POLL_EN.
module lcd_bus_reader #(
    parameter int T_AS  = 3,
    parameter int T_EH  = 13,
    parameter int T_AH  = 2,
    parameter int T_REC = 7
`ifdef LCD_RD_BUSY_POLL_EN
    ,
    parameter int POLL_MAX = 8
`endif
) (
    input  logic                iCLK_50MHZ,
    input  logic                iRST_N,
    lcd_bus_reader_if.slave     rd,
    output logic                bus_own,
    output logic                LCD_RW,
    output logic                LCD_RS,
    output logic                LCD_E,
    input  logic [7:0]          DATA_BUS
`ifdef LCD_RD_BUSY_POLL_EN
    ,
    input  logic                poll_req,
    output logic                lcd_ready,
    output logic                poll_timeout
`endif
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EHIGH, S_HOLD, S_RECOVER} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rs_q, rs_d;
    logic               e_q, e_d;
    logic               own_q, own_d;
    logic               valid_q, valid_d;
    logic [7:0]         data_q;
    logic               sample;
    logic               last_rec;
    logic               reissue;
    logic               start;
    logic               start_rs;

    assign last_rec = (state_q == S_RECOVER) && (cnt_q == '0);

`ifdef LCD_RD_BUSY_POLL_EN
    localparam logic [7:0] POLL_MAX_C = 8'(POLL_MAX);

    logic       polling_q, polling_d;
    logic [7:0] pcnt_q, pcnt_d;
    logic       ready_q, ready_d;
    logic       tmo_q, tmo_d;

    assign reissue  = polling_q && data_q[7] && (pcnt_q < POLL_MAX_C);
    assign start    = rd.rd_ready && (poll_req || rd.rd_req);
    assign start_rs = poll_req ? 1'b0 : rd.rd_rs;
`else
    assign reissue  = 1'b0;
    assign start    = rd.rd_ready && rd.rd_req;
    assign start_rs = rd.rd_rs;
`endif

    // The last RECOVER cycle already accepts, so back-to-back reads repeat every
    // T_AS+T_EH+T_AH+T_REC cycles with no idle gap.
    assign rd.rd_ready = (state_q == S_IDLE) || (last_rec && !reissue);

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        rs_d    = rs_q;
        e_d     = e_q;
        own_d   = own_q;
        valid_d = 1'b0;
        sample  = 1'b0;
`ifdef LCD_RD_BUSY_POLL_EN
        polling_d = polling_q;
        pcnt_d    = pcnt_q;
        ready_d   = 1'b0;
        tmo_d     = 1'b0;
`endif
        case (state_q)
            S_SETUP: if (cnt_q == '0) begin
                state_d = S_EHIGH;
                cnt_d   = CNT_W'(T_EH - 1);
                e_d     = 1'b1;
            end
            // Data is captured on the same edge that drops E, while the LCD still drives it.
            S_EHIGH: if (cnt_q == '0) begin
                state_d = S_HOLD;
                cnt_d   = CNT_W'(T_AH - 1);
                e_d     = 1'b0;
                sample  = 1'b1;
            end
            S_HOLD: if (cnt_q == '0) begin
                state_d = S_RECOVER;
                cnt_d   = CNT_W'(T_REC - 1);
                own_d   = 1'b0;
                valid_d = 1'b1;
            end
            S_RECOVER: if (cnt_q == '0) begin
                state_d = S_IDLE;
`ifdef LCD_RD_BUSY_POLL_EN
                if (polling_q) begin
                    if (reissue) begin
                        state_d = S_SETUP;
                        cnt_d   = CNT_W'(T_AS - 1);
                        own_d   = 1'b1;
                        pcnt_d  = pcnt_q + 8'd1;
                    end else begin
                        polling_d = 1'b0;
                        if (data_q[7]) tmo_d = 1'b1;
                        else           ready_d = 1'b1;
                    end
                end
`endif
            end
            default: ;
        endcase

        if (start) begin
            state_d = S_SETUP;
            cnt_d   = CNT_W'(T_AS - 1);
            own_d   = 1'b1;
            rs_d    = start_rs;
`ifdef LCD_RD_BUSY_POLL_EN
            polling_d = poll_req;
            pcnt_d    = 8'd1;
`endif
        end
    end

    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            own_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
            own_q   <= own_d;
            valid_q <= valid_d;
            if (sample) data_q <= DATA_BUS;
        end
    end

`ifdef LCD_RD_BUSY_POLL_EN
    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            polling_q <= 1'b0;
            pcnt_q    <= 8'd0;
            ready_q   <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            polling_q <= polling_d;
            pcnt_q    <= pcnt_d;
            ready_q   <= ready_d;
            tmo_q     <= tmo_d;
        end
    end

    assign lcd_ready    = ready_q;
    assign poll_timeout = tmo_q;
`endif

    assign bus_own     = own_q;
    assign LCD_RW      = own_q;
    assign LCD_RS      = own_q & rs_q;
    assign LCD_E       = e_q;
    assign rd.rd_valid = valid_q;
    assign rd.rd_data  = data_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Self-checking bench for lcd_bus_reader: vector table of single reads plus
// back-to-back, ignored-request and mid-cycle reset sequences.
module tb_lcd_bus_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bus_own, lcd_rw, lcd_rs, lcd_e;
    logic [7:0] data_bus = 8'hEE;
    logic [7:0] model_val = 8'h00;
    logic [7:0] last_data = 8'h00;
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    always #10 clk = ~clk;

    lcd_bus_reader_if rd_if();

`ifdef LCD_RD_BUSY_POLL_EN
    logic poll_req = 1'b0;
    logic lcd_ready, poll_timeout;
`endif

    lcd_bus_reader dut (
        .iCLK_50MHZ (clk),
        .iRST_N     (rst_n),
        .rd         (rd_if.slave),
        .bus_own    (bus_own),
        .LCD_RW     (lcd_rw),
        .LCD_RS     (lcd_rs),
        .LCD_E      (lcd_e),
        .DATA_BUS   (data_bus)
`ifdef LCD_RD_BUSY_POLL_EN
        ,
        .poll_req     (poll_req),
        .lcd_ready    (lcd_ready),
        .poll_timeout (poll_timeout)
`endif
    );

    // LCD model: bus holds junk until 160 ns after E rises, then the model byte until E falls.
    always begin
        @(posedge lcd_e);
        data_bus = 8'hEE;
        #160;
        if (lcd_e) data_bus = model_val;
        wait (!lcd_e);
        #5 data_bus = 8'hEE;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every rd_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rd_if.rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_valid: got rd_data 0x%0h expected no rd_valid", rd_if.rd_data);
            end else begin
                chk("sb_rd_data", {24'h0, rd_if.rd_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!rd_if.rd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rd_if.rd_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: got rd_ready=0 expected 1 within 100 cycles", name);
        end
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] bus_val;
        logic       exp_rs;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;

    task automatic do_read(input vec_t v);
        int cyc = 0;
        int ehigh = 0;
        int first_e = 0;
        model_val = v.bus_val;
        wait_ready("vec_ready");
        rd_if.rd_req = 1'b1;
        rd_if.rd_rs  = v.rs;
        exp_q.push_back(v.exp_data);
        @(posedge clk);
        #1;
        rd_if.rd_req = 1'b0;
        chk("vec_own_k1", {31'h0, bus_own}, 32'd1);
        chk("vec_rw_k1", {31'h0, lcd_rw}, 32'd1);
        chk("vec_rs_k1", {31'h0, lcd_rs}, {31'h0, v.exp_rs});
        chk("vec_e_k1", {31'h0, lcd_e}, 32'd0);
        while (!rd_if.rd_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (lcd_e) begin
                ehigh++;
                if (first_e == 0) first_e = cyc;
            end
            if (cyc == 15) chk("vec_hold_before_fall", {24'h0, rd_if.rd_data}, {24'h0, last_data});
        end
        chk("vec_valid_latency", cyc, v.exp_lat);
        chk("vec_e_rise_cycle", first_e, 32'd3);
        chk("vec_e_high_cycles", ehigh, 32'd13);
        chk("vec_own_after", {31'h0, bus_own}, 32'd0);
        chk("vec_rs_after", {31'h0, lcd_rs}, 32'd0);
        @(posedge clk);
        #1;
        chk("vec_valid_one_cycle", {31'h0, rd_if.rd_valid}, 32'd0);
        chk("vec_data_held", {24'h0, rd_if.rd_data}, {24'h0, v.exp_data});
        last_data = v.exp_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   rises, cyc, low_run, min_low, valids, n;
        int   rise_t[3];
        logic prev_e, own_seen;

        vecs[0] = '{1'b1, 8'h41, 1'b1, 8'h41, 18};
        vecs[1] = '{1'b0, 8'h85, 1'b0, 8'h85, 18};
        vecs[2] = '{1'b1, 8'h00, 1'b1, 8'h00, 18};
        vecs[3] = '{1'b1, 8'hFF, 1'b1, 8'hFF, 18};
        vecs[4] = '{1'b0, 8'h5A, 1'b0, 8'h5A, 18};
        vecs[5] = '{1'b1, 8'hC3, 1'b1, 8'hC3, 18};

        rd_if.rd_req = 1'b0;
        rd_if.rd_rs  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, rd_if.rd_ready}, 32'd1);
        chk("rst_valid", {31'h0, rd_if.rd_valid}, 32'd0);
        chk("rst_data", {24'h0, rd_if.rd_data}, 32'd0);
        chk("rst_own", {31'h0, bus_own}, 32'd0);
        chk("rst_rw", {31'h0, lcd_rw}, 32'd0);
        chk("rst_rs", {31'h0, lcd_rs}, 32'd0);
        chk("rst_e", {31'h0, lcd_e}, 32'd0);

        for (int i = 0; i < 6; i++) do_read(vecs[i]);

        // Back-to-back reads with rd_req held high.
        model_val = 8'h85;
        wait_ready("b2b_ready");
        rd_if.rd_rs  = 1'b0;
        rd_if.rd_req = 1'b1;
        rises = 0; cyc = 0; low_run = 0; min_low = 1000;
        prev_e = 1'b0; own_seen = 1'b0;
        rise_t[0] = 0; rise_t[1] = 0; rise_t[2] = 0;
        while (rises < 3 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (lcd_e && !prev_e) begin
                rise_t[rises] = cyc;
                rises++;
                exp_q.push_back(8'h85);
            end
            prev_e = lcd_e;
            if (!bus_own) low_run++;
            else begin
                if (own_seen && low_run > 0 && low_run < min_low) min_low = low_run;
                low_run = 0;
                own_seen = 1'b1;
            end
        end
        rd_if.rd_req = 1'b0;
        chk("b2b_rises", rises, 32'd3);
        chk("b2b_period1", rise_t[1] - rise_t[0], 32'd25);
        chk("b2b_period2", rise_t[2] - rise_t[1], 32'd25);
        chk("b2b_own_gap_ge7", {31'h0, min_low >= 7 && min_low < 1000}, 32'd1);
        wait_ready("b2b_done");
        chk("b2b_rd_data", {24'h0, rd_if.rd_data}, 32'h85);
        last_data = 8'h85;

        // rd_req pulsed during EHIGH must be dropped.
        model_val = 8'h3C;
        wait_ready("ign_ready");
        rd_if.rd_rs  = 1'b1;
        rd_if.rd_req = 1'b1;
        exp_q.push_back(8'h3C);
        @(posedge clk);
        #1;
        rd_if.rd_req = 1'b0;
        n = 0;
        while (!lcd_e && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ign_e_high", {31'h0, lcd_e}, 32'd1);
        rd_if.rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_if.rd_req = 1'b0;
        rises = 1; valids = 0; prev_e = lcd_e;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (lcd_e && !prev_e) rises++;
            prev_e = lcd_e;
            if (rd_if.rd_valid) valids++;
        end
        chk("ign_e_pulses", rises, 32'd1);
        chk("ign_valids", valids, 32'd1);
        chk("ign_rd_data", {24'h0, rd_if.rd_data}, 32'h3C);
        last_data = 8'h3C;

        // Asynchronous reset while E is high.
        model_val = 8'hA5;
        wait_ready("mrst_ready");
        rd_if.rd_rs  = 1'b1;
        rd_if.rd_req = 1'b1;
        exp_q.push_back(8'hA5);
        @(posedge clk);
        #1;
        rd_if.rd_req = 1'b0;
        n = 0;
        while (!lcd_e && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        chk("mrst_e", {31'h0, lcd_e}, 32'd0);
        chk("mrst_own", {31'h0, bus_own}, 32'd0);
        chk("mrst_rw", {31'h0, lcd_rw}, 32'd0);
        chk("mrst_rs", {31'h0, lcd_rs}, 32'd0);
        chk("mrst_valid", {31'h0, rd_if.rd_valid}, 32'd0);
        chk("mrst_data", {24'h0, rd_if.rd_data}, 32'd0);
        chk("mrst_ready", {31'h0, rd_if.rd_ready}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        valids = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (rd_if.rd_valid) valids++;
        end
        chk("mrst_no_valid", valids, 32'd0);
        chk("mrst_ready_after", {31'h0, rd_if.rd_ready}, 32'd1);
        last_data = 8'h00;

        do_read(vecs[1]);

        repeat (5) @(posedge clk);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
